// File: rtl/dram_sched_pkg.sv
// rtl/dram_sched_pkg.sv - shared command/state encodings and address constants for the DRAM command sequencer
package dram_sched_pkg;

  localparam int AP_BIT      = 10;
  localparam int DRAM_ADDR_W = 17;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_RD   = 3'd1,
    CMD_WR   = 3'd2,
    CMD_ACT  = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_REF  = 3'd5,
    CMD_PREA = 3'd6
  } dram_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_RW,
    ST_CAS_WAIT,
    ST_REF_PREA,
    ST_REF_PWAIT,
    ST_REF,
    ST_REF_WAIT
  } seq_state_e;

endpackage

// File: rtl/bank_row_table.sv
// rtl/bank_row_table.sv - per-bank open/row registers with combinational hit/closed/miss lookup
module bank_row_table #(
  parameter int NUM_BANKS = 16,
  parameter int BANK_W    = 4,
  parameter int ROW_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BANK_W-1:0]   lookup_bank,
  input  logic [ROW_BITS-1:0] lookup_row,
  output logic                hit,
  output logic                closed,
  output logic                miss,
  output logic                any_open,
  input  logic                open_en,
  input  logic [BANK_W-1:0]   open_bank,
  input  logic [ROW_BITS-1:0] open_row,
  input  logic                close_en,
  input  logic [BANK_W-1:0]   close_bank,
  input  logic                clear_all
);

  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

  // Lookup of the requested bank against its recorded open row
  always_comb begin
    hit      = open_q[lookup_bank] && (row_q[lookup_bank] == lookup_row);
    closed   = !open_q[lookup_bank];
    miss     = open_q[lookup_bank] && (row_q[lookup_bank] != lookup_row);
    any_open = |open_q;
  end

  // Bank state updates; clear_all dominates, an open in the same cycle as a close wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else if (clear_all) begin
      open_q <= '0;
    end else begin
      if (close_en) open_q[close_bank] <= 1'b0;
      if (open_en) begin
        open_q[open_bank] <= 1'b1;
        row_q[open_bank]  <= open_row;
      end
    end
  end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - DDR4 PRE/ACT/RD/WR/REF sequencer, open-page policy; CLOSED_PAGE_EN selects auto-precharge
module dram_cmd_sequencer
  import dram_sched_pkg::*;
#(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int REFRESH_LATENCY    = 20,
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_we_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
  input  logic [ROW_BITS-1:0]                req_row_in,
  input  logic [COL_BITS-1:0]                req_col_in,
  input  logic                               refresh_req_in,
  output logic                               refresh_ack_out,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     cmd_bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] cmd_ba_out,
  output logic [DRAM_ADDR_W-1:0]             cmd_addr_out,
  output logic                               done_valid_out,
  output logic                               done_we_out,
  output logic                               busy_out
);

  localparam int BG_W      = $clog2(BANK_GROUPS);
  localparam int BA_W      = $clog2(BANKS_PER_GROUP);
  localparam int BANK_W    = BG_W + BA_W;
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int MAX_AP    = (CAS_LATENCY > ACTIVATION_LATENCY) ? CAS_LATENCY : ACTIVATION_LATENCY;
  localparam int MAX_PR    = (PRECHARGE_LATENCY > REFRESH_LATENCY) ? PRECHARGE_LATENCY : REFRESH_LATENCY;
  localparam int MAX_LAT   = (MAX_AP > MAX_PR) ? MAX_AP : MAX_PR;
  localparam int CNT_W     = $clog2(MAX_LAT + 1);

  // Counters hold LATENCY-1 during the issue cycle, so each latency is assumed to be at least 2
  localparam logic [CNT_W-1:0] CAS_LOAD = CNT_W'(CAS_LATENCY - 1);
  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACTIVATION_LATENCY - 1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRECHARGE_LATENCY - 1);
  localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REFRESH_LATENCY - 1);

  localparam logic [DRAM_ADDR_W-1:0] PREA_ADDR = DRAM_ADDR_W'(1) << AP_BIT;

`ifdef CLOSED_PAGE_EN
  localparam logic CLOSED_PAGE = 1'b1;

  // Auto-precharge runs under the CAS wait, so the bank must be precharged before done lets a new ACT in
  if (PRECHARGE_LATENCY > CAS_LATENCY) begin : g_pre_lat_check
    $error("PRECHARGE_LATENCY must not exceed CAS_LATENCY with auto-precharge");
  end
`else
  localparam logic CLOSED_PAGE = 1'b0;
`endif

  seq_state_e          state;
  dram_cmd_e           cmd_q;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [BG_W-1:0]     lat_bg;
  logic [BA_W-1:0]     lat_ba;
  logic [ROW_BITS-1:0] lat_row;
  logic [COL_BITS-1:0] lat_col;
  logic                hit, closed, miss, any_open;
  logic                tbl_open, tbl_close, tbl_clear;

  function automatic logic [DRAM_ADDR_W-1:0] rw_addr(input logic [COL_BITS-1:0] col);
    rw_addr         = DRAM_ADDR_W'(col);
    rw_addr[AP_BIT] = CLOSED_PAGE;
  endfunction

  assign cmd_out       = cmd_q;
  assign busy_out      = (state != ST_IDLE);
  assign req_ready_out = rst_N_in && (state == ST_IDLE) && !refresh_req_in;

  // Bank table follows the registered command stream; lookups only matter in IDLE, after the update lands
  always_comb begin
    tbl_open  = cmd_valid_out && (cmd_q == CMD_ACT);
    tbl_close = cmd_valid_out && ((cmd_q == CMD_PRE) ||
                (CLOSED_PAGE && ((cmd_q == CMD_RD) || (cmd_q == CMD_WR))));
    tbl_clear = cmd_valid_out && ((cmd_q == CMD_PREA) || (cmd_q == CMD_REF));
  end

  bank_row_table #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W),
    .ROW_BITS  (ROW_BITS)
  ) u_bank_row_table (
    .clk         (clk_in),
    .rst_n       (rst_N_in),
    .lookup_bank ({req_bg_in, req_ba_in}),
    .lookup_row  (req_row_in),
    .hit         (hit),
    .closed      (closed),
    .miss        (miss),
    .any_open    (any_open),
    .open_en     (tbl_open),
    .open_bank   ({cmd_bg_out, cmd_ba_out}),
    .open_row    (lat_row),
    .close_en    (tbl_close),
    .close_bank  ({cmd_bg_out, cmd_ba_out}),
    .clear_all   (tbl_clear)
  );

  // Sequencer FSM: issue states pulse one registered command, wait states count down to the next issue
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      cmd_q           <= CMD_NOP;
      cmd_valid_out   <= 1'b0;
      cmd_bg_out      <= '0;
      cmd_ba_out      <= '0;
      cmd_addr_out    <= '0;
      done_valid_out  <= 1'b0;
      done_we_out     <= 1'b0;
      refresh_ack_out <= 1'b0;
      lat_we          <= 1'b0;
      lat_bg          <= '0;
      lat_ba          <= '0;
      lat_row         <= '0;
      lat_col         <= '0;
    end else begin
      cmd_valid_out   <= 1'b0;
      cmd_q           <= CMD_NOP;
      cmd_bg_out      <= '0;
      cmd_ba_out      <= '0;
      cmd_addr_out    <= '0;
      done_valid_out  <= 1'b0;
      refresh_ack_out <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (refresh_req_in) begin
            cmd_valid_out <= 1'b1;
            if (any_open) begin
              state        <= ST_REF_PREA;
              cmd_q        <= CMD_PREA;
              cmd_addr_out <= PREA_ADDR;
              cnt          <= PRE_LOAD;
            end else begin
              state <= ST_REF;
              cmd_q <= CMD_REF;
              cnt   <= REF_LOAD;
            end
          end else if (req_valid_in) begin
            lat_we        <= req_we_in;
            lat_bg        <= req_bg_in;
            lat_ba        <= req_ba_in;
            lat_row       <= req_row_in;
            lat_col       <= req_col_in;
            cmd_valid_out <= 1'b1;
            cmd_bg_out    <= req_bg_in;
            cmd_ba_out    <= req_ba_in;
            case ({hit, closed, miss})
              3'b100: begin
                state        <= ST_RW;
                cmd_q        <= req_we_in ? CMD_WR : CMD_RD;
                cmd_addr_out <= rw_addr(req_col_in);
                cnt          <= CAS_LOAD;
              end
              3'b010: begin
                state        <= ST_ACT;
                cmd_q        <= CMD_ACT;
                cmd_addr_out <= DRAM_ADDR_W'(req_row_in);
                cnt          <= ACT_LOAD;
              end
              default: begin
                state <= ST_PRE;
                cmd_q <= CMD_PRE;
                cnt   <= PRE_LOAD;
              end
            endcase
          end
        end
        ST_PRE:       state <= ST_PRE_WAIT;
        ST_ACT:       state <= ST_ACT_WAIT;
        ST_RW:        state <= ST_CAS_WAIT;
        ST_REF_PREA:  state <= ST_REF_PWAIT;
        ST_REF:       state <= ST_REF_WAIT;
        ST_PRE_WAIT: begin
          if (cnt == '0) begin
            state         <= ST_ACT;
            cmd_valid_out <= 1'b1;
            cmd_q         <= CMD_ACT;
            cmd_bg_out    <= lat_bg;
            cmd_ba_out    <= lat_ba;
            cmd_addr_out  <= DRAM_ADDR_W'(lat_row);
            cnt           <= ACT_LOAD;
          end
        end
        ST_ACT_WAIT: begin
          if (cnt == '0) begin
            state         <= ST_RW;
            cmd_valid_out <= 1'b1;
            cmd_q         <= lat_we ? CMD_WR : CMD_RD;
            cmd_bg_out    <= lat_bg;
            cmd_ba_out    <= lat_ba;
            cmd_addr_out  <= rw_addr(lat_col);
            cnt           <= CAS_LOAD;
          end
        end
        ST_CAS_WAIT: begin
          if (cnt == '0) begin
            state          <= ST_IDLE;
            done_valid_out <= 1'b1;
            done_we_out    <= lat_we;
          end
        end
        ST_REF_PWAIT: begin
          if (cnt == '0) begin
            state         <= ST_REF;
            cmd_valid_out <= 1'b1;
            cmd_q         <= CMD_REF;
            cnt           <= REF_LOAD;
          end
        end
        ST_REF_WAIT: begin
          if (cnt == '0) begin
            state           <= ST_IDLE;
            refresh_ack_out <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
